// File: rtl/text_fetch_ctrl_pkg.sv
// text_fetch_ctrl_pkg: raster timing constants, alignment bundle and glyph helper
// shared by the text fetch sequencer.
package text_fetch_ctrl_pkg;

    localparam logic [11:0] H_ACTIVE_MIN = 12'd0;
    localparam logic [11:0] H_ACTIVE_MAX = 12'd639;
    localparam logic [11:0] H_SYNC_MIN   = 12'd656;
    localparam logic [11:0] H_SYNC_MAX   = 12'd751;
    localparam logic [11:0] V_ACTIVE_MIN = 12'd0;
    localparam logic [11:0] V_ACTIVE_MAX = 12'd479;
    localparam logic [11:0] V_SYNC_MIN   = 12'd490;
    localparam logic [11:0] V_SYNC_MAX   = 12'd491;

    localparam int DEF_CHAR_W       = 8;
    localparam int DEF_CHAR_H       = 16;
    localparam int DEF_COLS         = 80;
    localparam int DEF_ROWS         = 30;
    localparam int DEF_TXT_AW       = 12;
    localparam int DEF_BLINK_FRAMES = 30;
    localparam int LAT              = 5;

    // Raster position and sync bits carried alongside the fetch pipeline.
    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        va;
        logic [11:0] h;
        logic [11:0] v;
    } align_t;

    // ROM rows are stored MSB-leftmost, so pixel x selects bit 7-x.
    function automatic logic glyph_bit(input logic [7:0] row, input logic [2:0] x);
        return row[~x];
    endfunction

endpackage

// File: rtl/text_fetch_ctrl_delay_line.sv
// delay_line: DEPTH-stage register chain of WIDTH bits, cleared by async active-low reset.
module delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sr [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
        end else begin
            sr[0] <= d;
            for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
    end

    assign q = sr[DEPTH-1];

endmodule

// File: rtl/text_fetch_ctrl.sv
// text_fetch_ctrl: raster position -> text RAM -> glyph ROM -> pixel, with aligned
// syncs, underline cursor, blink timing and a vblank-synchronised cursor update.
module text_fetch_ctrl
    import text_fetch_ctrl_pkg::*;
#(
    parameter int CHAR_W       = DEF_CHAR_W,
    parameter int CHAR_H       = DEF_CHAR_H,
    parameter int COLS         = DEF_COLS,
    parameter int ROWS         = DEF_ROWS,
    parameter int TXT_AW       = DEF_TXT_AW,
    parameter int BLINK_FRAMES = DEF_BLINK_FRAMES
) (
    input  logic                          pix_clk,
    input  logic                          rst,
    input  logic [11:0]                   H_count,
    input  logic [11:0]                   V_count,
    input  logic                          hsync,
    input  logic                          vsync,
    input  logic                          vid_active,
    output logic [TXT_AW-1:0]             txt_addr,
    input  logic [7:0]                    txt_data,
    output logic [7+$clog2(CHAR_H):0]     rom_addr,
    input  logic [7:0]                    rom_data,
    output logic                          pix,
    output logic                          hsync_o,
    output logic                          vsync_o,
    output logic                          vid_active_o,
    input  logic                          cur_valid,
    input  logic [6:0]                    cur_col,
    input  logic [4:0]                    cur_row,
    output logic                          cur_ready
);

    localparam int CW = $clog2(CHAR_W);
    localparam int GW = $clog2(CHAR_H);
    localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] PEND  = 2'd1;
    localparam logic [1:0] APPLY = 2'd2;

    align_t            a0, a2, a4;
    logic [TXT_AW-1:0] row_base, base_eff;
    logic [FW-1:0]     frame_cnt;
    logic              blink;
    logic [6:0]        cur_c, pend_c;
    logic [4:0]        cur_r, pend_r;
    logic [1:0]        state, state_nx;
    logic              row_clr, row_end, frame_end, hit;

    assign a0 = {hsync, vsync, vid_active, H_count, V_count};

    // First tap feeds the glyph-row half of rom_addr; second tap lines up with rom_data.
    delay_line #(.WIDTH($bits(align_t)), .DEPTH(2)) u_fetch_dly (
        .clk(pix_clk), .rst_n(rst), .d(a0), .q(a2)
    );
    delay_line #(.WIDTH($bits(align_t)), .DEPTH(LAT - 3)) u_pix_dly (
        .clk(pix_clk), .rst_n(rst), .d(a2), .q(a4)
    );

    assign row_clr   = V_count == V_ACTIVE_MIN && H_count == 12'd0;
    assign row_end   = H_count == H_SYNC_MAX && V_count[GW-1:0] == GW'(CHAR_H - 1)
                       && V_count <= V_ACTIVE_MAX;
    assign frame_end = H_count == H_SYNC_MAX && V_count == V_SYNC_MAX;
    // The clear is forwarded so the very first cell of a frame already reads from 0.
    assign base_eff  = row_clr ? '0 : row_base;

    assign hit = (a4.h >> CW) == 12'(cur_c) && (a4.v >> GW) == 12'(cur_r)
                 && a4.v[GW-1:0] >= GW'(CHAR_H - 2) && blink
                 && int'(cur_c) < COLS && int'(cur_r) < ROWS;

    assign cur_ready = state == IDLE;

    always_comb
        state_nx = state == IDLE ? (cur_valid ? PEND : IDLE)
                 : state == PEND ? (V_count > V_ACTIVE_MAX ? APPLY : PEND)
                 : IDLE;

    always_ff @(posedge pix_clk or negedge rst) begin
        if (!rst) begin
            txt_addr     <= '0;
            rom_addr     <= '0;
            pix          <= 1'b0;
            hsync_o      <= 1'b0;
            vsync_o      <= 1'b0;
            vid_active_o <= 1'b0;
            row_base     <= '0;
        end else begin
            txt_addr     <= base_eff + TXT_AW'(H_count >> CW);
            rom_addr     <= {txt_data, a2.v[GW-1:0]};
            pix          <= (glyph_bit(rom_data, a4.h[2:0]) ^ hit) & a4.va;
            hsync_o      <= a4.hs;
            vsync_o      <= a4.vs;
            vid_active_o <= a4.va;
            row_base     <= row_end ? base_eff + TXT_AW'(COLS) : base_eff;
        end
    end

    always_ff @(posedge pix_clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            pend_c    <= '0;
            pend_r    <= '0;
            cur_c     <= '0;
            cur_r     <= '0;
            blink     <= 1'b1;
            frame_cnt <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && cur_valid) begin
                pend_c <= cur_col;
                pend_r <= cur_row;
            end
            if (state == APPLY) begin
                cur_c     <= pend_c;
                cur_r     <= pend_r;
                blink     <= 1'b1;
                frame_cnt <= '0;
            end else if (frame_end) begin
                frame_cnt <= frame_cnt == FW'(BLINK_FRAMES - 1) ? '0 : frame_cnt + FW'(1);
                blink     <= blink ^ (frame_cnt == FW'(BLINK_FRAMES - 1));
            end
        end
    end

endmodule

// File: tb/tb_text_fetch_ctrl.sv
// tb_text_fetch_ctrl: table-driven pipeline vectors plus directed sequences for
// row base, reset, cursor handshake, blink and out-of-range cursor.
module tb_text_fetch_ctrl;

    logic        pix_clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] H_count = '0, V_count = '0;
    logic        hsync = 1'b0, vsync = 1'b0, vid_active = 1'b0;
    logic [11:0] txt_addr;
    logic [7:0]  txt_data = '0;
    logic [11:0] rom_addr;
    logic [7:0]  rom_data = '0;
    logic        pix, hsync_o, vsync_o, vid_active_o;
    logic        cur_valid = 1'b0;
    logic [6:0]  cur_col = '0;
    logic [4:0]  cur_row = '0;
    logic        cur_ready;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [11:0] h;
        logic [11:0] v;
        logic        hs;
        logic        vs;
        logic        va;
        logic        exp_pix;
    } vec_t;

    vec_t tbl[16];

    text_fetch_ctrl dut (
        .pix_clk(pix_clk), .rst(rst), .H_count(H_count), .V_count(V_count),
        .hsync(hsync), .vsync(vsync), .vid_active(vid_active),
        .txt_addr(txt_addr), .txt_data(txt_data), .rom_addr(rom_addr), .rom_data(rom_data),
        .pix(pix), .hsync_o(hsync_o), .vsync_o(vsync_o), .vid_active_o(vid_active_o),
        .cur_valid(cur_valid), .cur_col(cur_col), .cur_row(cur_row), .cur_ready(cur_ready)
    );

    always #5 pix_clk = ~pix_clk;

    // Text RAM: 'A' at 0, 'B' at 1, blanks elsewhere. Glyph ROM: 'A' row 0 = 0x80, 'B' every row = 0x24.
    always @(posedge pix_clk) begin
        txt_data <= txt_addr == 12'd0 ? 8'h41 : txt_addr == 12'd1 ? 8'h42 : 8'h00;
        rom_data <= rom_addr == 12'h410 ? 8'h80 : rom_addr[11:4] == 8'h42 ? 8'h24 : 8'h00;
    end

    task automatic tick;
        @(posedge pix_clk);
        #1;
    endtask

    task automatic drive(input logic [11:0] h, v, input logic hs, vs, va);
        H_count = h;
        V_count = v;
        hsync = hs;
        vsync = vs;
        vid_active = va;
    endtask

    task automatic idle;
        drive(12'd100, 12'd200, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic render(input logic [11:0] h, v, input logic e, input string nm);
        drive(h, v, 1'b0, 1'b0, 1'b1);
        tick;
        idle;
        repeat (4) tick;
        chk(nm, pix, e);
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            drive(12'd751, 12'd491, 1'b0, 1'b1, 1'b0);
            tick;
        end
        idle;
    endtask

    task automatic do_reset;
        idle;
        rst = 1'b0;
        tick;
        tick;
        rst = 1'b1;
    endtask

    task automatic request(input logic [6:0] c, input logic [4:0] r);
        cur_col = c;
        cur_row = r;
        cur_valid = 1'b1;
        tick;
        cur_valid = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{12'd0,  12'd0, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[1]  = '{12'd1,  12'd0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{12'd2,  12'd0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[3]  = '{12'd3,  12'd0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[4]  = '{12'd4,  12'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{12'd5,  12'd0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{12'd6,  12'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{12'd7,  12'd0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[8]  = '{12'd0,  12'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{12'd8,  12'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{12'd0,  12'd1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{12'd0,  12'd0, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[12] = '{12'd7,  12'd0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[13] = '{12'd10, 12'd0, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[14] = '{12'd13, 12'd3, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[15] = '{12'd12, 12'd0, 1'b0, 1'b0, 1'b1, 1'b0};

        idle;
        #2;
        chk("reset_outputs", {txt_addr, rom_addr, pix, hsync_o, vsync_o, vid_active_o}, 0);
        chk("reset_ready", cur_ready, 1);
        tick;
        rst = 1'b1;

        for (int i = 0; i < 20; i++) begin
            if (i < 16) drive(tbl[i].h, tbl[i].v, tbl[i].hs, tbl[i].vs, tbl[i].va);
            else idle;
            tick;
            if (i >= 4)
                chk($sformatf("vec%0d", i - 4), {pix, hsync_o, vsync_o, vid_active_o},
                    {tbl[i-4].exp_pix, tbl[i-4].hs, tbl[i-4].vs, tbl[i-4].va});
        end

        drive(12'd0, 12'd0, 1'b0, 1'b0, 1'b1); tick; chk("rb_clear", txt_addr, 0);
        drive(12'd751, 12'd15, 1'b1, 1'b0, 1'b0); tick;
        drive(12'd8, 12'd16, 1'b0, 1'b0, 1'b1); tick; chk("rb_row1", txt_addr, 81);
        for (int v = 31; v <= 463; v += 16) begin
            drive(12'd751, 12'(v), 1'b1, 1'b0, 1'b0);
            tick;
        end
        drive(12'd0, 12'd479, 1'b0, 1'b0, 1'b1); tick; chk("rb_row29", txt_addr, 2320);
        drive(12'd751, 12'd479, 1'b1, 1'b0, 1'b0); tick;
        drive(12'd751, 12'd491, 1'b1, 1'b1, 1'b0); tick;
        drive(12'd0, 12'd0, 1'b0, 1'b0, 1'b1); tick; chk("rb_next_frame", txt_addr, 0);
        drive(12'd16, 12'd0, 1'b0, 1'b0, 1'b1); tick; chk("rb_next_col2", txt_addr, 2);

        drive(12'd16, 12'd200, 1'b1, 1'b1, 1'b1);
        request(7'd3, 5'd2);
        repeat (5) tick;
        chk("mid_pend_ready", cur_ready, 0);
        chk("mid_busy", {hsync_o, vsync_o, vid_active_o}, 3'b111);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_reset_outputs", {txt_addr, rom_addr, pix, hsync_o, vsync_o, vid_active_o}, 0);
        chk("mid_reset_ready", cur_ready, 1);
        tick;
        rst = 1'b1;
        drive(12'd0, 12'd0, 1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            tick;
            idle;
            chk($sformatf("post_rst_pix%0d", k), pix, k == 5);
        end
        drive(12'd0, 12'd480, 1'b0, 1'b0, 1'b0);
        repeat (3) tick;
        render(12'd0, 12'd14, 1'b1, "discard_old_cursor");
        render(12'd24, 12'd46, 1'b0, "discard_pending");

        do_reset;
        drive(12'd0, 12'd100, 1'b0, 1'b0, 1'b1);
        request(7'd3, 5'd2);
        chk("hs_ready_low", cur_ready, 0);
        cur_col = 7'd5;
        cur_row = 5'd5;
        cur_valid = 1'b1;
        render(12'd0, 12'd14, 1'b1, "hs_unchanged");
        drive(12'd0, 12'd479, 1'b0, 1'b0, 1'b1); tick;
        chk("hs_ready_479", cur_ready, 0);
        cur_valid = 1'b0;
        drive(12'd0, 12'd480, 1'b0, 1'b0, 1'b0); tick;
        chk("hs_apply", cur_ready, 0);
        tick;
        chk("hs_ready_back", cur_ready, 1);
        render(12'd24, 12'd46, 1'b1, "hs_new_cursor");
        render(12'd0, 12'd14, 1'b0, "hs_old_gone");
        render(12'd40, 12'd94, 1'b0, "hs_ignored_req");

        drive(12'd0, 12'd490, 1'b0, 1'b1, 1'b0);
        request(7'd6, 5'd1);
        chk("vb_pend", cur_ready, 0);
        tick;
        chk("vb_apply", cur_ready, 0);
        tick;
        chk("vb_idle", cur_ready, 1);
        render(12'd51, 12'd31, 1'b1, "vb_cursor");

        do_reset;
        render(12'd0, 12'd14, 1'b1, "cur_r14");
        render(12'd7, 12'd15, 1'b1, "cur_r15");
        render(12'd0, 12'd13, 1'b0, "cur_r13");
        render(12'd8, 12'd14, 1'b0, "cur_col1");
        frames(29);
        render(12'd3, 12'd15, 1'b1, "blink_29");
        frames(1);
        render(12'd0, 12'd14, 1'b0, "blink_30");
        render(12'd7, 12'd15, 1'b0, "blink_30b");
        frames(30);
        render(12'd0, 12'd14, 1'b1, "blink_60");

        drive(12'd0, 12'd490, 1'b0, 1'b1, 1'b0);
        request(7'd80, 5'd0);
        repeat (3) tick;
        for (int p = 0; p < 4; p++) begin
            render(12'd640, 12'd14, 1'b0, $sformatf("oor_col80_%0d", p));
            render(12'd0, 12'd14, 1'b0, $sformatf("oor_col0_%0d", p));
            frames(30);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
